state_dump_unit: RTL and testbench

Synthesizable architectural-state dump engine for the 8-bit RISC RNS core. On a start pulse it sequentially reads the register file and a selectable window of data memory, then streams each word out as a tagged record over a valid/ready handshake. It sits beside processor_top and replaces end-of-simulation hierarchical peeks with a hardware path usable in simulation, on FPGA and by a host debug link.

---
 rtl/state_dump_unit.sv | 175 +++++++++++++++++
 tb/tb_state_dump_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/state_dump_unit.sv
// rtl/state_dump_unit.sv - register-file / data-memory state dump engine streaming tagged records
// Optional checksum record: define DUMP_CHECKSUM_EN.
module state_dump_unit #(
  parameter int DATA_W   = 8,
  parameter int RF_DEPTH = 8,
  parameter int RF_AW    = 3,
  parameter int DM_DEPTH = 256,
  parameter int DM_AW    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rf_en,
  input  logic [DM_AW-1:0]  dm_base,
  input  logic [DM_AW:0]    dm_len,
  output logic              busy,
  output logic              done,
  output logic [RF_AW-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [DM_AW-1:0]  dm_rd_addr,
  input  logic [DATA_W-1:0] dm_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_space,
  output logic [DM_AW-1:0]  out_index,
  output logic [DATA_W-1:0] out_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_RF_OUT, S_DM_ADDR, S_DM_OUT, S_FINISH, S_CSUM
  } state_e;

  localparam logic [DM_AW:0] DM_DEPTH_L = (DM_AW+1)'(DM_DEPTH);
  localparam logic [RF_AW-1:0] RF_LAST = RF_AW'(RF_DEPTH - 1);

  state_e             state_q, state_d;
  logic [RF_AW-1:0]   rf_idx_q, rf_idx_d;
  logic [DM_AW-1:0]   dm_addr_q, dm_addr_d;
  logic [DM_AW:0]     dm_rem_q, dm_rem_d;
  // hold_q marks that the live read data was frozen into data_q during a stall
  logic               hold_q, hold_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  live_data;
  logic [DM_AW:0]     len_clamped;
  state_e             after_data;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]  sum_q, sum_d;
`endif

  assign len_clamped = (dm_len > DM_DEPTH_L) ? DM_DEPTH_L : dm_len;
  assign rf_rd_addr  = rf_idx_q;
  assign dm_rd_addr  = dm_addr_q;
`ifdef DUMP_CHECKSUM_EN
  assign after_data  = S_CSUM;
`else
  assign after_data  = S_FINISH;
`endif

  // State, counters and stall-capture register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rf_idx_q  <= '0;
      dm_addr_q <= '0;
      dm_rem_q  <= '0;
      hold_q    <= 1'b0;
      data_q    <= '0;
`ifdef DUMP_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rf_idx_q  <= rf_idx_d;
      dm_addr_q <= dm_addr_d;
      dm_rem_q  <= dm_rem_d;
      hold_q    <= hold_d;
      data_q    <= data_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  // Next-state sequencing, record presentation and stall hold
  always_comb begin
    state_d   = state_q;
    rf_idx_d  = rf_idx_q;
    dm_addr_d = dm_addr_q;
    dm_rem_d  = dm_rem_q;
    hold_d    = hold_q;
    data_d    = data_q;
`ifdef DUMP_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    out_space = 2'd0;
    out_index = '0;
    live_data = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dm_addr_d = dm_base;
          dm_rem_d  = len_clamped;
          rf_idx_d  = '0;
          hold_d    = 1'b0;
`ifdef DUMP_CHECKSUM_EN
          sum_d     = '0;
`endif
          if (rf_en)                 state_d = S_RF_OUT;
          else if (len_clamped != 0) state_d = S_DM_ADDR;
          else                       state_d = S_FINISH;
        end
      end
      S_RF_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_index = {{(DM_AW-RF_AW){1'b0}}, rf_idx_q};
        live_data = rf_rd_data;
        if (out_ready) begin
          if (rf_idx_q == RF_LAST) begin
            rf_idx_d = '0;
            state_d  = (dm_rem_q != 0) ? S_DM_ADDR : after_data;
          end else begin
            rf_idx_d = rf_idx_q + RF_AW'(1);
          end
        end
      end
      S_DM_ADDR: begin
        busy    = 1'b1;
        state_d = S_DM_OUT;
      end
      S_DM_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_space = 2'd1;
        out_index = dm_addr_q;
        live_data = dm_rd_data;
        if (out_ready) begin
          dm_addr_d = dm_addr_q + DM_AW'(1);
          dm_rem_d  = dm_rem_q - (DM_AW+1)'(1);
          state_d   = (dm_rem_q == (DM_AW+1)'(1)) ? after_data : S_DM_ADDR;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_space = 2'd2;
        live_data = sum_q;
        if (out_ready) state_d = S_FINISH;
      end
`endif
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    out_data = hold_q ? data_q : live_data;
    if (out_valid && out_ready) begin
      hold_d = 1'b0;
    end else if (out_valid && !hold_q) begin
      hold_d = 1'b1;
      data_d = live_data;
    end
`ifdef DUMP_CHECKSUM_EN
    if (out_valid && out_ready && state_q != S_CSUM) sum_d = sum_q + out_data;
`endif
  end

endmodule

// File: tb/tb_state_dump_unit.sv
// tb/tb_state_dump_unit.sv - directed self-checking bench for state_dump_unit
module tb_state_dump_unit;

  logic       clk = 1'b0;
  logic       reset, start, rf_en, out_ready;
  logic [7:0] dm_base;
  logic [8:0] dm_len;
  logic       busy, done, out_valid;
  logic [2:0] rf_rd_addr;
  logic [7:0] rf_rd_data, dm_rd_addr, dm_rd_data, out_index, out_data;
  logic [1:0] out_space;

  logic [7:0] rf [8];
  logic [7:0] mem [256];

  int errors = 0;
  int checks = 0;
  int done_cnt, cyc_done;

  logic [1:0] got_sp[$], exp_sp[$];
  logic [7:0] got_ix[$], exp_ix[$];
  logic [7:0] got_dt[$], exp_dt[$];

  always #5 clk = ~clk;

  assign rf_rd_data = rf[rf_rd_addr];
  always @(posedge clk) dm_rd_data <= mem[dm_rd_addr];

  state_dump_unit dut (
    .clk(clk), .reset(reset), .start(start), .rf_en(rf_en),
    .dm_base(dm_base), .dm_len(dm_len), .busy(busy), .done(done),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .dm_rd_addr(dm_rd_addr), .dm_rd_data(dm_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_space(out_space),
    .out_index(out_index), .out_data(out_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] sp, input logic [7:0] ix, input logic [7:0] dt);
    exp_sp.push_back(sp);
    exp_ix.push_back(ix);
    exp_dt.push_back(dt);
  endtask

  task automatic clear_exp();
    exp_sp.delete();
    exp_ix.delete();
    exp_dt.delete();
  endtask

  task automatic add_csum();
`ifdef DUMP_CHECKSUM_EN
    logic [7:0] s;
    s = 8'd0;
    foreach (exp_dt[i]) s = s + exp_dt[i];
    push_exp(2'd2, 8'd0, s);
`endif
  endtask

  task automatic run_dump(input logic ren, input logic [7:0] base, input logic [8:0] len,
                          input bit stall, input int restart_at, input int budget);
    logic       pstall;
    logic [1:0] psp;
    logic [7:0] pix, pdt;
    got_sp.delete();
    got_ix.delete();
    got_dt.delete();
    done_cnt = 0;
    cyc_done = -1;
    pstall   = 1'b0;
    rf_en    = ren;
    dm_base  = base;
    dm_len   = len;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (k == restart_at) begin
        start   = 1'b1;
        rf_en   = 1'b1;
        dm_base = 8'd99;
        dm_len  = 9'd9;
      end else begin
        start = 1'b0;
      end
      out_ready = stall ? (k % 3 == 2) : 1'b1;
      if (pstall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_record", {out_space, out_index, out_data}, {psp, pix, pdt});
      end
      pstall = out_valid && !out_ready;
      psp = out_space;
      pix = out_index;
      pdt = out_data;
      if (out_valid && out_ready) begin
        got_sp.push_back(out_space);
        got_ix.push_back(out_index);
        got_dt.push_back(out_data);
      end
      if (done) begin
        done_cnt++;
        cyc_done = k;
        break;
      end
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", done_cnt, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic cmp_records(input string tag);
    chk({tag, "_count"}, got_sp.size(), exp_sp.size());
    for (int i = 0; i < exp_sp.size() && i < got_sp.size(); i++) begin
      chk({tag, "_space"}, got_sp[i], exp_sp[i]);
      chk({tag, "_index"}, got_ix[i], exp_ix[i]);
      chk({tag, "_data"},  got_dt[i], exp_dt[i]);
    end
  endtask

  initial begin
    int csum_extra;
`ifdef DUMP_CHECKSUM_EN
    csum_extra = 1;
`else
    csum_extra = 0;
`endif
    reset = 1'b0; start = 1'b0; rf_en = 1'b0; out_ready = 1'b1;
    dm_base = 8'd0; dm_len = 9'd0;
    for (int i = 0; i < 8; i++) rf[i] = 8'(10 + i);
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

    // reset held: start must have no effect
    repeat (2) @(negedge clk);
    start = 1'b1; rf_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    chk("rst_valid2", out_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_busy", busy, 0);
    chk("rel_done", done, 0);
    chk("rel_valid", out_valid, 0);
    chk("rel_space", out_space, 0);
    chk("rel_index", out_index, 0);
    chk("rel_data", out_data, 0);
    chk("rel_rf_addr", rf_rd_addr, 0);
    chk("rel_dm_addr", dm_rd_addr, 0);

    // register file only, records on consecutive cycles
    clear_exp();
    for (int i = 0; i < 8; i++) push_exp(2'd0, 8'(i), 8'(10 + i));
    add_csum();
    run_dump(1'b1, 8'd0, 9'd0, 1'b0, -1, 40);
    cmp_records("rf");
    chk("rf_cycles", cyc_done, 8 + csum_extra);

    // memory window wrapping 255 -> 0
    mem[254] = 8'd1; mem[255] = 8'd2; mem[0] = 8'd3; mem[1] = 8'd4;
    clear_exp();
    push_exp(2'd1, 8'd254, 8'd1);
    push_exp(2'd1, 8'd255, 8'd2);
    push_exp(2'd1, 8'd0, 8'd3);
    push_exp(2'd1, 8'd1, 8'd4);
    add_csum();
    run_dump(1'b0, 8'd254, 9'd4, 1'b0, -1, 40);
    cmp_records("wrap");
    chk("wrap_cycles", cyc_done, 8 + csum_extra);

    // same window with back-pressure
    run_dump(1'b0, 8'd254, 9'd4, 1'b1, -1, 80);
    cmp_records("stall");

    // empty dump
    clear_exp();
    run_dump(1'b0, 8'd0, 9'd0, 1'b0, -1, 10);
    cmp_records("empty");
    chk("empty_cycles", cyc_done, 0);

    // start while busy is ignored
    clear_exp();
    push_exp(2'd1, 8'd10, mem[10]);
    push_exp(2'd1, 8'd11, mem[11]);
    add_csum();
    run_dump(1'b0, 8'd10, 9'd2, 1'b0, 2, 40);
    cmp_records("restart");

    // oversized length clamps to full memory
    clear_exp();
    for (int i = 0; i < 256; i++) push_exp(2'd1, 8'(i), mem[i]);
    add_csum();
    run_dump(1'b0, 8'd0, 9'd300, 1'b0, -1, 600);
    cmp_records("clamp");

    // reset mid-dump aborts at once with no done
    rf_en = 1'b1; dm_len = 9'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_valid_before", out_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_valid_abort", out_valid, 0);
    chk("mid_busy_abort", busy, 0);
    chk("mid_index_abort", out_index, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_done", done, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rel_busy", busy, 0);
    chk("mid_rel_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
